// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debounce FSM.
// Latency: none (package only).
// Backpressure: none (package only).
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;
    localparam int MAP_W    = NUM_ROWS * NUM_COLS;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } dbnc_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_class_t;

    // Result of one completed scan: how many keys were down and, for a
    // single key, which one.
    typedef struct packed {
        scan_class_t       cls;
        logic [CODE_W-1:0] key;
    } scan_res_t;

    // Popcount-based classification of a full pressed map.
    function automatic scan_res_t classify(input logic [MAP_W-1:0] map);
        scan_res_t res;
        int        cnt;
        cnt     = 0;
        res.key = '0;
        for (int i = 0; i < MAP_W; i++) begin
            if (map[i]) begin
                cnt++;
                res.key = CODE_W'(i);
            end
        end
        if (cnt == 0) begin
            res.cls = SCAN_NONE;
        end else if (cnt == 1) begin
            res.cls = SCAN_SINGLE;
        end else begin
            res.cls = SCAN_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Debounces classified scan results into an accepted key code, valid pulse and held flag.
// Latency: key_valid/key_held register one cycle after the accepting scan end.
// Backpressure: none; key_valid is a one-cycle pulse the consumer must take.
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_end,
    input  scan_res_t         scan_res,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dbnc_state_t       state, state_d;
    logic [CODE_W-1:0] cand, cand_d;
    logic [CNT_W-1:0]  stab_cnt, stab_cnt_d;
    logic [CNT_W-1:0]  rel_cnt, rel_cnt_d;
    logic [CODE_W-1:0] key_code_d;
    logic              key_valid_d;
    logic              same_key;

    assign same_key = (scan_res.cls == SCAN_SINGLE) && (scan_res.key == cand);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            stab_cnt  <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_d;
            cand      <= cand_d;
            stab_cnt  <= stab_cnt_d;
            rel_cnt   <= rel_cnt_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_held  <= (state_d == PRESSED);
        end
    end

    // Next-state logic; only a scan end moves the FSM or its counters.
    always_comb begin
        state_d     = state;
        cand_d      = cand;
        stab_cnt_d  = stab_cnt;
        rel_cnt_d   = rel_cnt;
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (scan_res.cls == SCAN_SINGLE) begin
                        cand_d     = scan_res.key;
                        stab_cnt_d = CNT_ONE;
                        state_d    = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (same_key) begin
                        // Saturating increment so the counter never wraps.
                        if (stab_cnt != CNT_MAX) begin
                            stab_cnt_d = stab_cnt + CNT_ONE;
                        end
                        if (stab_cnt_d == CNT_MAX) begin
                            key_code_d  = cand;
                            key_valid_d = 1'b1;
                            state_d     = PRESSED;
                        end
                    end else if (scan_res.cls == SCAN_SINGLE) begin
                        cand_d     = scan_res.key;
                        stab_cnt_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    // Any scan that is not exactly the held key counts toward release,
                    // so a direct key change behaves as a release first.
                    if (same_key) begin
                        rel_cnt_d = '0;
                    end else begin
                        if (rel_cnt != CNT_MAX) begin
                            rel_cnt_d = rel_cnt + CNT_ONE;
                        end
                        if (rel_cnt_d == CNT_MAX) begin
                            rel_cnt_d = '0;
                            state_d   = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad column scanner: synchronises rows, builds the pressed map and encodes row*4+col.
// Latency: key_valid one cycle after the end of the DEBOUNCE_SCANS-th stable scan.
// Backpressure: none; key_valid is a one-cycle pulse, key_code holds until the next acceptance.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic                multi_key
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W = $clog2(NUM_COLS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] row_meta, row_sync;
    logic [DIV_W-1:0]    div_cnt;
    logic [COL_W-1:0]    col_idx;
    logic [MAP_W-1:0]    key_map, map_next;
    logic                sample, scan_end;
    scan_res_t           scan_res;

    assign sample   = (div_cnt == DIV_LAST);
    assign scan_end = sample && (col_idx == COL_LAST);
    assign scan_res = classify(map_next);

    // Two-flop synchroniser; idle rows read high (pulled up).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Column slot timer and one-cold column rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col_idx <= '0;
            col_n   <= COL_RESET;
        end else if (sample) begin
            div_cnt <= '0;
            col_idx <= col_idx + COL_W'(1);
            col_n   <= {col_n[NUM_COLS-2:0], col_n[NUM_COLS-1]};
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Pressed map with the current column's rows merged in; at scan end this is the full scan.
    always_comb begin
        map_next = key_map;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (c == int'(col_idx)) begin
                    map_next[r*NUM_COLS + c] = ~row_sync[r];
                end
            end
        end
    end

    // Commit each column's sample and register the multi-key flag per completed scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_map   <= '0;
            multi_key <= 1'b0;
        end else begin
            if (sample) begin
                key_map <= map_next;
            end
            if (scan_end) begin
                multi_key <= (scan_res.cls == SCAN_MULTI);
            end
        end
    end

    keypad_debounce_fsm #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_end  (scan_end),
        .scan_res  (scan_res),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Scoreboard bench for keypad_scan_encoder driving a behavioural 4x4 key matrix.
// Latency: expected key_valid cycles are computed from the scan schedule.
// Backpressure: none; every key_valid pulse is popped from the scoreboard.
`timescale 1ns/1ps
module tb_keypad_scan_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [15:0] keys = '0;

    int cyc;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t sb_q[$];

    keypad_scan_encoder #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its row to the driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_n[c] && keys[r*4 + c]) row_n[r] = 1'b0;
            end
        end
    end

    // Cycle index since reset release; cycle 0 is the first column slot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) chk("wait_timeout", cyc, n);
    endtask

    task automatic push(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    // Every key_valid pulse must match the next expected acceptance.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'(key_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("valid_code", 32'(key_code), 32'(e.code));
                chk("valid_cycle", cyc, e.at);
                chk("held_at_valid", 32'(key_held), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b;
        logic [3:0] exp_col;

        // Reset state
        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        chk("rst_col_n",     32'(col_n),     32'hE);
        chk("rst_key_code",  32'(key_code),  32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_held",  32'(key_held),  32'h0);
        chk("rst_multi_key", 32'(multi_key), 32'h0);
        rst_n = 1'b1;

        // Column rotation: one slot every 4 cycles, period 16
        for (int i = 0; i < 32; i++) begin
            wait_cyc(i);
            exp_col = 4'b0001 << ((i / 4) % 4);
            exp_col = ~exp_col;
            chk("col_rotate", 32'(col_n), 32'(exp_col));
        end

        // Clean press of key 9 (row 2, col 1) for 5 scans, then release
        b = 32;
        wait_cyc(b);
        keys = 16'(1) << 9;
        push(4'd9, b + 48);
        wait_cyc(b + 47);
        chk("t2_held_before", 32'(key_held), 32'd0);
        wait_cyc(b + 48);
        chk("t2_held_rise", 32'(key_held), 32'd1);
        wait_cyc(b + 80);
        keys = '0;
        wait_cyc(b + 127);
        chk("t2_held_last", 32'(key_held), 32'd1);
        wait_cyc(b + 128);
        chk("t2_held_fall", 32'(key_held), 32'd0);
        chk("t2_code_hold", 32'(key_code), 32'd9);

        // Bounce: key 5 on alternate scans for 8 scans
        b = 176;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(b + 16*i);
            keys = (i % 2 == 0) ? (16'(1) << 5) : 16'h0;
        end
        wait_cyc(b + 128);
        chk("t3_held", 32'(key_held), 32'd0);
        chk("t3_code", 32'(key_code), 32'd9);

        // Multi-key: 0 and 15 for 4 scans, then only 0
        b = 304;
        wait_cyc(b);
        keys = 16'h8001;
        wait_cyc(b + 15);
        chk("t4_multi_before", 32'(multi_key), 32'd0);
        wait_cyc(b + 16);
        chk("t4_multi_set", 32'(multi_key), 32'd1);
        wait_cyc(b + 63);
        chk("t4_multi_hold", 32'(multi_key), 32'd1);
        chk("t4_no_held", 32'(key_held), 32'd0);
        wait_cyc(b + 64);
        keys = 16'h0001;
        push(4'd0, b + 112);
        wait_cyc(b + 79);
        chk("t4_multi_last", 32'(multi_key), 32'd1);
        wait_cyc(b + 80);
        chk("t4_multi_clr", 32'(multi_key), 32'd0);
        wait_cyc(b + 128);
        keys = '0;
        wait_cyc(b + 175);
        chk("t4_held_last", 32'(key_held), 32'd1);
        wait_cyc(b + 176);
        chk("t4_held_fall", 32'(key_held), 32'd0);

        // Direct change from key 3 to key 12 while held
        b = 496;
        wait_cyc(b);
        keys = 16'(1) << 3;
        push(4'd3, b + 48);
        wait_cyc(b + 64);
        keys = 16'(1) << 12;
        push(4'd12, b + 160);
        wait_cyc(b + 111);
        chk("t5_held_last", 32'(key_held), 32'd1);
        chk("t5_code_old", 32'(key_code), 32'd3);
        wait_cyc(b + 112);
        chk("t5_held_fall", 32'(key_held), 32'd0);
        wait_cyc(b + 170);
        chk("t5_code_new", 32'(key_code), 32'd12);

        // Reset during DEBOUNCE of key 7, key kept held through reset
        b = 688;
        wait_cyc(b);
        keys = '0;
        wait_cyc(b + 64);
        keys = 16'(1) << 7;
        wait_cyc(b + 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_col_n",     32'(col_n),     32'hE);
        chk("t6_rst_key_code",  32'(key_code),  32'h0);
        chk("t6_rst_key_valid", 32'(key_valid), 32'h0);
        chk("t6_rst_key_held",  32'(key_held),  32'h0);
        chk("t6_rst_multi_key", 32'(multi_key), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(4'd7, 48);
        wait_cyc(47);
        chk("t6_held_before", 32'(key_held), 32'd0);
        chk("t6_code_before", 32'(key_code), 32'd0);
        wait_cyc(60);
        chk("t6_held", 32'(key_held), 32'd1);
        chk("t6_code", 32'(key_code), 32'd7);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
4x4 matrix keypad scanner and encoder that produces the 4-bit key code consumed by the downstream binary-to-one-hot (hexadecimal) decoder stage.
- Drives the keypad columns one at a time and samples the rows.
- Debounces over whole scans and reports one valid pulse per debounced press.
- Flags multi-key presses and reports no code for them.

Parameters:
SCAN_DIV, 4, clock cycles each column stays driven; minimum 3 (covers 2-flop sync latency).
DEBOUNCE_SCANS, 3, consecutive full scans needed to accept a press or a release; minimum 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
col_n  output  4  column drive, active-low, exactly one bit low at any time.
key_code  output  4  last accepted key, code = row*4 + col; feeds decoder X.
key_valid  output  1  single-cycle pulse when a new key is accepted.
key_held  output  1  high from acceptance until the release is debounced.
multi_key  output  1  high when the last completed scan saw more than one key.

Behaviour:
Reset state (async assert, sync release):
- col_n=4'b1110, key_code=0, key_valid=0, key_held=0, multi_key=0.
- All counters are 0; FSM is IDLE.

Row synchronisation:
- row_n passes through a 2-flop synchroniser. Only the synchronised value is used.

Scan timing:
- div_cnt counts 0..SCAN_DIV-1. When it wraps, col_n rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Rows are sampled at div_cnt==SCAN_DIV-1 of each column slot.
- Active-low rows are inverted into a 16-bit pressed map: bit (row*4+col) is set when row r reads 0 during column c.
- Scan end is the sample cycle of column 3. One scan is 4*SCAN_DIV cycles.

Scan-end evaluation (combinational on the completed map):
- none: popcount==0.
- single(k): popcount==1, k is the set bit's index.
- multi: popcount>1.
- multi_key is registered at every scan end: 1 if multi, else 0.

Debounce FSM (advances only at scan end):
- IDLE: on single(k), set cand=k, stab_cnt=1, go DEBOUNCE. Otherwise stay.
- DEBOUNCE:
  - single(cand): increment stab_cnt. When the new value equals DEBOUNCE_SCANS, set key_code=cand, pulse key_valid on the next cycle, go PRESSED.
  - single(other k): set cand=k, stab_cnt=1, stay in DEBOUNCE.
  - none or multi: go IDLE.
- PRESSED: key_held=1.
  - single(cand): rel_cnt=0.
  - Anything else: increment rel_cnt. When it reaches DEBOUNCE_SCANS, rel_cnt=0, go IDLE.

Output behaviour:
- key_valid is high for exactly 1 cycle per accepted press, registered one cycle after the scan-end sample.
- key_code holds its value until the next acceptance. It never changes outside a key_valid cycle.
- key_held is a registered decode of the PRESSED state.

Latency:
- A key stable before scan 1 produces key_valid one cycle after the end of scan DEBOUNCE_SCANS.

Boundary conditions:
- Key change while PRESSED counts as a release. The new key is debounced from IDLE afterwards, with no glitch pulse.
- A multi-key scan never produces key_valid.
- A release shorter than DEBOUNCE_SCANS scans does not re-trigger.
- The stab_cnt and rel_cnt counters saturate and never wrap.
- Reset mid-operation returns to the reset state immediately. A key held through reset is re-debounced from IDLE.

Decomposition:
Shared package keypad_pkg holds:
- NUM_ROWS=4, NUM_COLS=4, CODE_W=4.
- The FSM state enum {IDLE, DEBOUNCE, PRESSED}.
- The COL_RESET=4'b1110 constant.

Natural sub-module: keypad_debounce_fsm. It takes scan_end, the none/single/multi classification and k. It returns key_code, key_valid and key_held. The top module keeps the synchroniser, scan counter, column drive, map and popcount.

Test Plan:
1. Reset: assert rst_n=0 mid-scan -> col_n=1110 and all outputs 0 immediately. After release, col_n rotates every 4 cycles, period 16.
2. Clean press: row 2 low whenever col 1 is driven, for 5 scans -> exactly one key_valid with key_code=9, one cycle after scan-3 end. key_held=1 until 3 scans after release.
3. Bounce: key 5 present on alternate scans for 8 scans -> no key_valid, key_held stays 0, key_code unchanged.
4. Multi-key: codes 0 and 15 pressed together for 4 scans -> multi_key=1 from scan-1 end, no key_valid. Release key 15 -> multi_key=0 at next scan end, key_valid with code 0 after 3 more scans.
5. Direct change while held: key 3 accepted, then switch to key 12 with no release gap -> key_held falls at scan-3 end of the change. key_valid with code 12 follows one cycle after scan-6 end.
6. Reset during DEBOUNCE: key 7 held for 2 scans, rst_n pulse, key kept held -> key_valid with code 7 only after 3 full scans post-reset.
